// File: rtl/arb_pkg.sv
// Shared types and the round-robin search for the 8-way arbiter.
// The search is a plain function so the top stays a single flat FSM.
package arb_pkg;

  localparam int N_REQ      = 8;
  localparam int IDX_W      = 3;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Walk from the farthest offset back to 'start' so the closest set bit wins last.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] start);
    pick_t            p;
    logic [IDX_W-1:0] pos;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = start + IDX_W'(i);
      if (req[pos]) begin
        p.found = 1'b1;
        p.idx   = pos;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dec3to8_en.sv
// Enabled 3-to-8 decoder driving the shared resource select lines.
// Output is all-zero when en is low, so at most one line is ever high.
module dec3to8_en
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant held until release.
// Optional grant timeout is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int HOLD_MAX = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] next_idx;
  logic [N_REQ-1:0] other_req;
  pick_t            pick_idle;
  pick_t            pick_hand;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  timeout_q, timeout_d;
`endif

  assign next_idx  = idx_q + IDX_W'(1);
  // The released owner is masked so it can never win its own handoff.
  assign other_req = req & ~(N_REQ'(1) << idx_q);
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_hand = rr_pick(other_req, next_idx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && (req != '0)) begin
          idx_d   = pick_idle.idx;
          state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          ptr_d = next_idx;
          if (en && pick_hand.found) begin
            idx_d  = pick_hand.idx;
`ifdef ARB_TIMEOUT_EN
            hold_d = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          ptr_d     = next_idx;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == BUSY);

  dec3to8_en u_dec (
    .idx (idx_q),
    .en  (gnt_valid),
    .dec (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: directed scenarios then random traffic,
// expectations from a queue-free owner/pointer model of the arbitration rules.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_HOLD = 4;
  rr_arbiter8 #(.HOLD_MAX(TB_HOLD)) dut (
`else
  rr_arbiter8 dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic       valid;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model: owner is -1 when nobody holds the resource
  int m_owner, m_ptr, m_last, m_hold;
  logic m_to;

  function automatic int search(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    int cand;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (e && r != 8'h00) begin
        m_owner = search(r, m_ptr);
        m_hold  = 1;
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 8;
      cand  = e ? search(r & ~(8'h01 << m_owner), m_ptr) : -1;
      m_last = m_owner;
      m_owner = cand;
      m_hold  = 1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == TB_HOLD) begin
        m_ptr   = (m_owner + 1) % 8;
        m_last  = m_owner;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end
    if (m_owner >= 0) m_last = m_owner;
  endtask

  task automatic drive_cycle(input logic [7:0] r, input logic e);
    exp_t x;
    @(negedge clk);
    req = r;
    en  = e;
    model_step(r, e);
    x.valid = (m_owner >= 0);
    x.gnt   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    x.idx   = 3'(m_last);
    x.to    = m_to;
    sb_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    en    = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // monitor: every clock the DUT presents a fresh registered grant state
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        if (gnt !== x.gnt || gnt_valid !== x.valid || gnt_idx !== x.idx ||
            timeout !== x.to || $countones(gnt) > 1) begin
          errors++;
          $display("FAIL sb: got gnt=%h v=%b idx=%0d to=%b expected gnt=%h v=%b idx=%0d to=%b at %0t",
                   gnt, gnt_valid, gnt_idx, timeout, x.gnt, x.valid, x.idx, x.to, $time);
        end
      end
    end
  end

  initial begin
    logic [7:0] cur;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    model_reset();
    #23;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset mid-grant
    drive_cycle(8'h10, 1'b1);
    drive_cycle(8'h10, 1'b1);
    @(posedge clk);
    #3;
    check("pre_rst_gnt", 32'(gnt), 32'h10);
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    model_reset();
    req   = 8'h00;
    rst_n = 1'b1;
    drive_cycle(8'h01, 1'b1);
    drive_cycle(8'h00, 1'b1);

    // single requester held five cycles
    for (int i = 0; i < 5; i++) drive_cycle(8'h08, 1'b1);
    drive_cycle(8'h00, 1'b1);
    drive_cycle(8'h00, 1'b1);

    // fairness and wrap with back-to-back handoff
    do_reset();
    drive_cycle(8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) drive_cycle(8'hFF & ~(8'h01 << m_owner), 1'b1);
    drive_cycle(8'h00, 1'b1);

    // handoff skips released owner
    do_reset();
    drive_cycle(8'h40, 1'b1);
    drive_cycle(8'h40, 1'b1);
    drive_cycle(8'h01, 1'b1);
    drive_cycle(8'h41, 1'b1);
    @(posedge clk);
    #2;
    check("skip_gnt", 32'(gnt), 32'h01);
    drive_cycle(8'h00, 1'b1);

    // enable gating
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(8'h22, 1'b0);
    drive_cycle(8'h22, 1'b1);
    @(posedge clk);
    #2;
    check("en_gnt", 32'(gnt), 32'h02);
    drive_cycle(8'h22, 1'b0);
    drive_cycle(8'h20, 1'b0);
    drive_cycle(8'h20, 1'b1);

    // long hold: unbounded, or revoked when the timeout is built
    do_reset();
    for (int i = 0; i < 20; i++) drive_cycle(8'h04, 1'b1);
    drive_cycle(8'h00, 1'b1);

    // random traffic with sticky request bits
    do_reset();
    cur = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      cur = cur ^ (8'($urandom) & 8'($urandom));
      drive_cycle(cur, ($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    @(posedge clk);
    #3;
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
